video_half_scaler: RTL and testbench
====================================

// Module: video_half_scaler
// PURPOSE
//  Per-channel 2:1 downscaler (2x2 box average, RGB565) upstream of the four-channel splicer.
//  Takes a full-size camera stream (default 1024x768) and emits the quarter-size tile
//  (512x384) on O_FS/O_wren/O_data, wired to one W_FS_n/W_wren_n/W_data_n splicer input.
//  Single line buffer of horizontal pair sums; one output pixel per 2x2 input block.
// PARAMETERS
//  IN_XSIZE   1024  input active pixels per line (even)
//  IN_YSIZE   768   input active lines per frame (even)
//  LB_AW      9     line-buffer address width; 2**LB_AW >= IN_XSIZE/2
// PORTS
//  I_clk      in   1   pixel clock; all logic on rising edge
//  I_rst      in   1   reset, synchronous, active-high
//  I_FS       in   1   input frame sync, level; rising edge starts a frame
//  I_de       in   1   input pixel valid; line ends on falling edge
//  I_data     in   16  input pixel RGB565 {R[15:11],G[10:5],B[4:0]}
//  O_FS       out  1   output frame sync = I_FS delayed 2 cycles
//  O_wren     out  1   output pixel valid (1-cycle pulses, <= 1 per 2 input cycles)
//  O_data     out  16  output pixel RGB565
//  O_ovf      out  1   1-cycle pulse: pixel/line beyond IN_XSIZE/IN_YSIZE dropped
// BEHAVIOUR
//  Reset: O_FS=0, O_wren=0, O_data=0, O_ovf=0, state=S_WAIT_FS, x=0, y=0; buffer RAM not cleared.
//  States: S_WAIT_FS -> S_EVEN on I_FS rising edge; S_EVEN -> S_ODD on I_de falling edge;
//   S_ODD -> S_EVEN on I_de falling edge, y+=2; y reaching IN_YSIZE -> S_DROP;
//   S_DROP/any state -> S_EVEN (x=0,y=0) on I_FS rising edge (also mid-line: partial line discarded).
//  S_WAIT_FS/S_DROP: pixels ignored; I_de pulses in S_DROP raise O_ovf once per line.
//  x counts I_de cycles in line, cleared on I_de falling edge. x>=IN_XSIZE: pixel dropped, O_ovf pulse.
//  Pair: x[0]=0 pixel latched; x[0]=1 pixel forms hsum = R:6b,G:7b,B:6b (19b) of the two.
//  S_EVEN: hsum written to linebuf[x>>1] same cycle as odd pixel; no output.
//  S_ODD: linebuf[x>>1] read issued on x[0]=0 cycle (1-cycle RAM); on x[0]=1 cycle stage-1
//   registers hsum and read data; stage-2 sums (R:7b,G:8b,B:7b), divides by 4, registers
//   O_data and O_wren=1. Latency: O_wren high 2 cycles after the I_de cycle of the odd pixel.
//  Odd trailing pixel of a short line (x ends even count+1) dropped, no output.
//  Short line in S_ODD: entries not rewritten this frame are read stale; output count = floor(len/2).
//  Read and write of same address never coincide (write only in S_EVEN, read only in S_ODD).
//  I_de falling edge and I_FS rising edge same cycle: FS wins (state S_EVEN, y=0).
//  O_FS = 2-stage delay of I_FS, so O_FS edge precedes first O_wren of the frame by >=1 line.
//  Width: all sums unsigned, no saturation needed (max 4*63=252 fits 8b).
// CONFIGURATION
//  SCALER_ROUND_EN defined: each component = (sum4 + 2) >> 2 (round half up; 4*max+2 still
//   fits: 254>>2=63, 126>>2=31). Undefined: (sum4) >> 2, truncation. No other difference.
// TESTING
//  Reset held 3 cycles mid-frame -> O_wren/O_FS/O_data/O_ovf all 0; no output until next I_FS edge.
//  1024x768 frame, all pixels 16'hFFFF -> exactly 196608 O_wren pulses, O_data=16'hFFFF,
//   first O_wren 2 cycles after pixel 1 of line 1.
//  Line0 pixels {16'h0000,16'h0841}, line1 {16'h0841,16'h0841} -> sum R=3,G=6,B=3;
//   O_data=16'h0020 (G=1, R=B=0) without SCALER_ROUND_EN, 16'h0841 with it.
//  Line of 1030 pixels -> 512 outputs on odd line, O_ovf pulses 6 times; next line unaffected.
//  I_FS rising edge at pixel 300 of line 101 -> partial line discarded, y=0, next line is even (no output).
//  770 lines in frame -> 384 output lines; lines 768-769 produce O_ovf once each, no O_wren.

Source files
------------

// File: rtl/video_half_scaler.sv
// 2:1 box-average downscaler for RGB565 video: one output pixel per 2x2 input block.
// Define SCALER_ROUND_EN to round each averaged component half-up instead of truncating.
module video_half_scaler #(
  parameter int IN_XSIZE = 1024,
  parameter int IN_YSIZE = 768,
  parameter int LB_AW    = 9
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_FS,
  input  logic        I_de,
  input  logic [15:0] I_data,
  output logic        O_FS,
  output logic        O_wren,
  output logic [15:0] O_data,
  output logic        O_ovf
);

  localparam int XW = $clog2(IN_XSIZE) + 2;
  localparam int YW = $clog2(IN_YSIZE) + 2;
  localparam logic [XW-1:0] X_LIM  = XW'(IN_XSIZE);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_YSIZE - 2);

  localparam logic [1:0] S_WAIT_FS = 2'd0;
  localparam logic [1:0] S_EVEN    = 2'd1;
  localparam logic [1:0] S_ODD     = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  logic [1:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          fs_prev, de_prev, skip;
  logic [1:0]    fs_pipe, vld_pipe;
  logic [15:0]   p0;
  logic [18:0]   hsum, rd_q, s1_h, s1_t;
  logic [18:0]   lb [0:(1<<LB_AW)-1];
  logic [5:0]    hr, hb;
  logic [6:0]    hg;
  logic [6:0]    r4, b4;
  logic [7:0]    g4;
  logic          fs_rise, de_fall, in_line, x_in, pix_ok, px_ovf, drop_ovf;
  logic          wr_en, rd_en, pair_odd;
  logic          unused_lsb;

  assign fs_rise  = I_FS & ~fs_prev;
  assign de_fall  = de_prev & ~I_de;
  // skip covers the tail of a line that was cut by a new frame sync
  assign in_line  = (state == S_EVEN || state == S_ODD) & I_de & ~skip & ~fs_rise;
  assign x_in     = x < X_LIM;
  assign pix_ok   = in_line & x_in;
  assign px_ovf   = in_line & ~x_in;
  assign drop_ovf = (state == S_DROP) & I_de & ~de_prev & ~fs_rise;
  assign wr_en    = pix_ok & x[0] & (state == S_EVEN);
  assign rd_en    = pix_ok & ~x[0] & (state == S_ODD);
  assign pair_odd = pix_ok & x[0] & (state == S_ODD);

  assign hr   = {1'b0, p0[15:11]} + {1'b0, I_data[15:11]};
  assign hg   = {1'b0, p0[10:5]}  + {1'b0, I_data[10:5]};
  assign hb   = {1'b0, p0[4:0]}   + {1'b0, I_data[4:0]};
  assign hsum = {hr, hg, hb};

  always_comb begin
    r4 = {1'b0, s1_h[18:13]} + {1'b0, s1_t[18:13]};
    g4 = {1'b0, s1_h[12:6]}  + {1'b0, s1_t[12:6]};
    b4 = {1'b0, s1_h[5:0]}   + {1'b0, s1_t[5:0]};
`ifdef SCALER_ROUND_EN
    r4 = r4 + 7'd2;
    g4 = g4 + 8'd2;
    b4 = b4 + 7'd2;
`endif
  end

  assign unused_lsb = ^{r4[1:0], g4[1:0], b4[1:0]};
  assign O_FS       = fs_pipe[1];
  assign O_wren     = vld_pipe[1];

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state    <= S_WAIT_FS;
      x        <= '0;
      y        <= '0;
      fs_prev  <= 1'b1;  // a level-high I_FS across reset is not a new frame
      de_prev  <= 1'b0;
      skip     <= 1'b0;
      fs_pipe  <= '0;
      vld_pipe <= '0;
      O_data   <= '0;
      O_ovf    <= 1'b0;
    end else begin
      fs_prev  <= I_FS;
      de_prev  <= I_de;
      fs_pipe  <= {fs_pipe[0], I_FS};
      vld_pipe <= {vld_pipe[0], pair_odd};
      O_ovf    <= px_ovf | drop_ovf;
      if (vld_pipe[0]) O_data <= {r4[6:2], g4[7:2], b4[6:2]};
      if (fs_rise) begin
        state <= S_EVEN;
        x     <= '0;
        y     <= '0;
        skip  <= I_de;
      end else if (de_fall) begin
        x    <= '0;
        skip <= 1'b0;
        if (!skip) begin
          case (state)
            S_EVEN: state <= S_ODD;
            S_ODD: begin
              y     <= y + YW'(2);
              state <= (y >= Y_LAST) ? S_DROP : S_EVEN;
            end
            default: ;
          endcase
        end
      end else if (I_de && x != '1) begin
        x <= x + XW'(1);
      end
    end
  end

  // Datapath and line buffer: no reset, contents only meaningful under the valid bits
  always_ff @(posedge I_clk) begin
    if (pix_ok && !x[0]) p0 <= I_data;
    if (wr_en) lb[x[LB_AW:1]] <= hsum;
    if (rd_en) rd_q <= lb[x[LB_AW:1]];
    if (pair_odd) begin
      s1_h <= hsum;
      s1_t <= rd_q;
    end
  end

endmodule

// File: tb/tb_video_half_scaler.sv
// Scoreboard bench for video_half_scaler on a reduced 16x8 frame.
module tb_video_half_scaler;
  localparam int X  = 16;
  localparam int Y  = 8;
  localparam int AW = 3;
`ifdef SCALER_ROUND_EN
  localparam logic [15:0] PAT_EXP = 16'h0841;
`else
  localparam logic [15:0] PAT_EXP = 16'h0020;
`endif

  logic        I_clk = 1'b0, I_rst = 1'b1, I_FS = 1'b0, I_de = 1'b0;
  logic [15:0] I_data = '0;
  logic        O_FS, O_wren, O_ovf;
  logic [15:0] O_data;

  video_half_scaler #(.IN_XSIZE(X), .IN_YSIZE(Y), .LB_AW(AW)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_FS(I_FS), .I_de(I_de), .I_data(I_data),
    .O_FS(O_FS), .O_wren(O_wren), .O_data(O_data), .O_ovf(O_ovf)
  );

  always #5 I_clk = ~I_clk;

  typedef struct { logic [15:0] d; int c; } exp_t;
  exp_t sb[$];

  int vec_cnt = 0, err_cnt = 0, cyc = 0;
  int wren_cnt = 0, ovf_cnt = 0, exp_ovf = 0, line_no = 0;
  int w0, o0;
  bit active = 0;
  logic [15:0] top [X];
  logic [15:0] last_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] avg4(input logic [15:0] a, b, c, d);
    int r, g, bb;
    r  = int'(a[15:11]) + int'(b[15:11]) + int'(c[15:11]) + int'(d[15:11]);
    g  = int'(a[10:5])  + int'(b[10:5])  + int'(c[10:5])  + int'(d[10:5]);
    bb = int'(a[4:0])   + int'(b[4:0])   + int'(c[4:0])   + int'(d[4:0]);
`ifdef SCALER_ROUND_EN
    r += 2; g += 2; bb += 2;
`endif
    r = r >> 2; g = g >> 2; bb = bb >> 2;
    return {r[4:0], g[5:0], bb[4:0]};
  endfunction

  always @(posedge I_clk) cyc <= cyc + 1;

  always @(negedge I_clk) begin
    exp_t e;
    if (O_ovf) ovf_cnt++;
    if (O_wren) begin
      wren_cnt++;
      last_data = O_data;
      if (sb.size() == 0) chk("spurious_wren", 1, 0);
      else begin
        e = sb.pop_front();
        chk("data", O_data, e.d);
        chk("latency", cyc, e.c);
      end
    end
  end

  // mode 0: all white, 1: fixed pattern, 2: random. cut_kind 1: FS at cut_at, 2: reset at cut_at
  task automatic drive_line(input int len, input int mode, input int cut_at = -1, input int cut_kind = 0);
    logic [15:0] p, prev;
    bit discard;
    discard = 0;
    prev = '0;
    for (int x = 0; x < len; x++) begin
      @(negedge I_clk);
      if (cut_kind == 2 && x == cut_at + 2) begin
        chk("rst_wren", O_wren, 0);
        chk("rst_fs", O_FS, 0);
        chk("rst_data", O_data, 0);
        chk("rst_ovf", O_ovf, 0);
      end
      if (cut_kind == 2 && x == cut_at + 3) I_rst = 1'b0;
      case (mode)
        0: p = 16'hFFFF;
        1: p = (line_no % 2 == 1 || x % 2 == 1) ? 16'h0841 : 16'h0000;
        default: p = 16'($urandom);
      endcase
      I_de = 1'b1;
      I_data = p;
      if (x == cut_at) begin
        discard = 1;
        if (cut_kind == 1) I_FS = 1'b1;
        else begin I_rst = 1'b1; active = 0; end
      end
      if (active && !discard) begin
        if (line_no >= Y) begin
          if (x == 0) exp_ovf++;
        end else if (x >= X) exp_ovf++;
        else if (line_no % 2 == 0) top[x] = p;
        else if (x % 2 == 1) sb.push_back('{avg4(top[x-1], top[x], prev, p), cyc + 2});
      end
      prev = p;
    end
    @(negedge I_clk);
    I_de = 1'b0;
    if (cut_kind == 1) I_FS = 1'b0;
    if (cut_kind == 2) I_rst = 1'b0;
    line_no = (cut_kind == 1 && discard) ? 0 : line_no + 1;
    repeat (3) @(negedge I_clk);
  endtask

  task automatic start_frame(input bit hold);
    @(negedge I_clk); I_FS = 1'b1;
    @(negedge I_clk); chk("ofs_d1", O_FS, 0);
    @(negedge I_clk); chk("ofs_d2", O_FS, 1);
    if (!hold) I_FS = 1'b0;
    line_no = 0;
    active = 1;
    repeat (2) @(negedge I_clk);
  endtask

  task automatic settle(input string tag, input int exp_w);
    repeat (4) @(negedge I_clk);
    chk(tag, wren_cnt - w0, exp_w);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge I_clk);
    chk("reset_wren", O_wren, 0);
    chk("reset_fs", O_FS, 0);
    chk("reset_data", O_data, 0);
    chk("reset_ovf", O_ovf, 0);
    I_rst = 1'b0;
    repeat (2) @(negedge I_clk);

    // full white frame
    w0 = wren_cnt;
    start_frame(0);
    for (int l = 0; l < Y; l++) drive_line(X, 0);
    settle("wren_white", X * Y / 4);
    chk("data_white", last_data, 16'hFFFF);

    // fixed pattern frame
    w0 = wren_cnt;
    start_frame(0);
    for (int l = 0; l < Y; l++) drive_line(X, 1);
    settle("wren_pat", X * Y / 4);
    chk("pat", last_data, PAT_EXP);

    // long line, short odd line, two extra lines past the frame
    w0 = wren_cnt; o0 = ovf_cnt;
    start_frame(0);
    drive_line(X, 2);
    drive_line(X + 6, 2);
    drive_line(X, 2);
    drive_line(7, 2);
    for (int l = 0; l < 6; l++) drive_line(X, 2);
    settle("wren_ovf_frame", 27);
    chk("ovf_frame", ovf_cnt - o0, 8);

    // frame sync in the middle of an odd line
    w0 = wren_cnt; o0 = ovf_cnt;
    start_frame(0);
    for (int l = 0; l < 3; l++) drive_line(X, 2);
    drive_line(X, 2, 5, 1);
    drive_line(X, 2);
    drive_line(X, 2);
    settle("wren_fs_cut", 18);
    chk("ovf_fs_cut", ovf_cnt - o0, 0);

    // reset mid-line with I_FS held high: nothing until a new FS edge
    w0 = wren_cnt; o0 = ovf_cnt;
    start_frame(1);
    drive_line(X, 2);
    drive_line(X, 2, 5, 2);
    drive_line(X, 2);
    drive_line(X + 6, 2);
    I_FS = 1'b0;
    settle("wren_reset", 2);
    chk("ovf_reset", ovf_cnt - o0, 0);

    chk("ovf_total", ovf_cnt, exp_ovf);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
